// File: rtl/pulse_generator_regbank.sv
// Per-channel shadow/active configuration bank for the pulse generators, with commits aligned to i_sync.
// Optional forced-commit timeout: define PGREG_SYNC_TIMEOUT_EN.
module pulse_generator_regbank #(
  parameter int unsigned           NUM_CH         = 4,
  parameter int unsigned           ADDR_WIDTH     = 8,
  parameter int unsigned           DATA_WIDTH     = 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = 8'h20,
  parameter int unsigned           CH_STRIDE_LOG2 = 5,
  parameter int unsigned           TIMEOUT_CYCLES = 1000000
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_wr,
  input  logic [ADDR_WIDTH-1:0]   i_addr,
  input  logic [DATA_WIDTH-1:0]   i_data,
  output logic [DATA_WIDTH-1:0]   o_data,
  input  logic [NUM_CH-1:0]       i_sync,
  output logic [NUM_CH-1:0]       o_pulse_enable,
  output logic [NUM_CH*16-1:0]    o_usr_year,
  output logic [NUM_CH*8-1:0]     o_usr_month,
  output logic [NUM_CH*8-1:0]     o_usr_day,
  output logic [NUM_CH*8-1:0]     o_usr_hour,
  output logic [NUM_CH*8-1:0]     o_usr_minutes,
  output logic [NUM_CH*8-1:0]     o_usr_seconds,
  output logic [NUM_CH*32-1:0]    o_width_high,
  output logic [NUM_CH*32-1:0]    o_width_period,
  output logic [NUM_CH-1:0]       o_commit_done
);

  if (DATA_WIDTH != 8 || NUM_CH < 1 || NUM_CH > 8 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("pulse_generator_regbank: unsupported parameter set");
  end

  typedef enum logic {IDLE, PENDING} cstate_t;

  // Byte-addressed config storage: index = register offset (2..16)
  logic [7:0]        shadow_q [NUM_CH][2:16];
  logic [7:0]        active_q [NUM_CH][2:16];
  logic [NUM_CH-1:0] sh_en_q, act_en_q, commit_q, to_flag_q;
  cstate_t           state_q [NUM_CH];
  cstate_t           state_d [NUM_CH];
  logic [NUM_CH-1:0] fire, to_hit, ch_hit;
  logic [ADDR_WIDTH-1:0] diff, ch_sel;
  int unsigned       off;
  logic [7:0]        rd_d;

  always_comb begin
    diff   = i_addr - BASE_ADDR;
    ch_sel = diff >> CH_STRIDE_LOG2;
    off    = 32'(diff[CH_STRIDE_LOG2-1:0]);
    ch_hit = '0;
    for (int unsigned c = 0; c < NUM_CH; c++)
      ch_hit[c] = (i_addr >= BASE_ADDR) && (ch_sel == ADDR_WIDTH'(c));
  end

  always_comb begin
    fire = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      state_d[c] = state_q[c];
      case (state_q[c])
        IDLE:
          if (i_wr && ch_hit[c] && off == 0 && i_data[1]) state_d[c] = PENDING;
        PENDING:
          if (i_sync[c] || !act_en_q[c] || to_hit[c]) begin
            fire[c]    = 1'b1;
            state_d[c] = IDLE;
          end
        default: state_d[c] = IDLE;
      endcase
    end
  end

  always_comb begin
    rd_d = '0;
    if (!i_wr) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (ch_hit[c]) begin
          if (off == 0) rd_d = {7'b0, sh_en_q[c]};
          if (off == 1) rd_d = {5'b0, to_flag_q[c], act_en_q[c], state_q[c] == PENDING};
          for (int unsigned r = 2; r <= 16; r++)
            if (off == r) rd_d = shadow_q[c][r];
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_data    <= '0;
      commit_q  <= '0;
      sh_en_q   <= '0;
      act_en_q  <= '0;
      to_flag_q <= '0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        state_q[c] <= IDLE;
        for (int unsigned r = 2; r <= 16; r++) begin
          shadow_q[c][r] <= '0;
          active_q[c][r] <= '0;
        end
      end
    end else begin
      o_data   <= rd_d;
      commit_q <= fire;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        state_q[c] <= state_d[c];
        // Active takes the pre-edge shadow even if a shadow write lands this cycle
        if (fire[c]) begin
          act_en_q[c] <= sh_en_q[c];
          for (int unsigned r = 2; r <= 16; r++) active_q[c][r] <= shadow_q[c][r];
        end
        if (i_wr && ch_hit[c]) begin
          if (off == 0) begin
            sh_en_q[c] <= i_data[0];
            if (i_data[2]) to_flag_q[c] <= 1'b0;
          end
          for (int unsigned r = 2; r <= 16; r++)
            if (off == r) shadow_q[c][r] <= i_data;
        end
        if (fire[c] && to_hit[c] && !i_sync[c]) to_flag_q[c] <= 1'b1;
      end
    end
  end

`ifdef PGREG_SYNC_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] to_cnt_q [NUM_CH];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned c = 0; c < NUM_CH; c++) to_cnt_q[c] <= '0;
    end else begin
      for (int unsigned c = 0; c < NUM_CH; c++)
        if (state_q[c] == PENDING && !fire[c]) to_cnt_q[c] <= to_cnt_q[c] + CNT_W'(1);
        else                                   to_cnt_q[c] <= '0;
    end
  end

  always_comb begin
    to_hit = '0;
    for (int unsigned c = 0; c < NUM_CH; c++)
      to_hit[c] = (state_q[c] == PENDING) && (to_cnt_q[c] == CNT_W'(TIMEOUT_CYCLES - 1));
  end
`else
  always_comb to_hit = '0;
`endif

  always_comb begin
    o_pulse_enable = act_en_q;
    o_commit_done  = commit_q;
    o_usr_year     = '0;
    o_usr_month    = '0;
    o_usr_day      = '0;
    o_usr_hour     = '0;
    o_usr_minutes  = '0;
    o_usr_seconds  = '0;
    o_width_high   = '0;
    o_width_period = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      o_usr_year[c*16 +: 16]     = {active_q[c][2], active_q[c][3]};
      o_usr_month[c*8 +: 8]      = active_q[c][4];
      o_usr_day[c*8 +: 8]        = active_q[c][5];
      o_usr_hour[c*8 +: 8]       = active_q[c][6];
      o_usr_minutes[c*8 +: 8]    = active_q[c][7];
      o_usr_seconds[c*8 +: 8]    = active_q[c][8];
      o_width_high[c*32 +: 32]   = {active_q[c][9], active_q[c][10], active_q[c][11], active_q[c][12]};
      o_width_period[c*32 +: 32] = {active_q[c][13], active_q[c][14], active_q[c][15], active_q[c][16]};
    end
  end

endmodule

// File: tb/tb_pulse_generator_regbank.sv
// Self-checking bench for pulse_generator_regbank: vector table, directed corner cases, random traffic vs. a register-map model.
module tb_pulse_generator_regbank;
  localparam int unsigned NUM_CH = 4;
  localparam int unsigned TO     = 16;

  logic                clk, rst_n, wr;
  logic [7:0]          addr, wdata, rdata;
  logic [NUM_CH-1:0]   sync, pen, done;
  logic [NUM_CH*16-1:0] year;
  logic [NUM_CH*8-1:0] month, day, hour, minutes, seconds;
  logic [NUM_CH*32-1:0] wh, wp;

  int checks = 0;
  int failures = 0;

  pulse_generator_regbank #(.NUM_CH(NUM_CH), .TIMEOUT_CYCLES(TO)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_wr(wr), .i_addr(addr), .i_data(wdata), .o_data(rdata),
    .i_sync(sync), .o_pulse_enable(pen), .o_usr_year(year), .o_usr_month(month),
    .o_usr_day(day), .o_usr_hour(hour), .o_usr_minutes(minutes), .o_usr_seconds(seconds),
    .o_width_high(wh), .o_width_period(wp), .o_commit_done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: register map contents and commit bookkeeping
  int unsigned sh   [NUM_CH][32];
  bit          aen  [NUM_CH];
  int unsigned ay [NUM_CH], am [NUM_CH], ad [NUM_CH], ah [NUM_CH], ami [NUM_CH], asec [NUM_CH];
  int unsigned awh [NUM_CH], awp [NUM_CH];
  bit          pend [NUM_CH];
  int unsigned age  [NUM_CH];
  bit          tflag[NUM_CH];
  logic [7:0]        m_data;
  logic [NUM_CH-1:0] m_done;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      for (int o = 0; o < 32; o++) sh[i][o] = 0;
      aen[i] = 0; ay[i] = 0; am[i] = 0; ad[i] = 0; ah[i] = 0; ami[i] = 0; asec[i] = 0;
      awh[i] = 0; awp[i] = 0; pend[i] = 0; age[i] = 0; tflag[i] = 0;
    end
    m_data = '0;
    m_done = '0;
  endtask

  task automatic model_edge(input bit w, input logic [7:0] a, input logic [7:0] d, input logic [NUM_CH-1:0] s);
    int unsigned snap [NUM_CH][32];
    bit was_pend [NUM_CH];
    int unsigned c, off;
    bit hit, forced;
    c = 0; off = 0; hit = 0;
    if (a >= 8'h20) begin
      c   = (int'(a) - 32) / 32;
      off = (int'(a) - 32) % 32;
      hit = (c < NUM_CH);
    end
    m_data = '0;
    if (!w && hit) begin
      if (off == 0)                    m_data = 8'(sh[c][0]);
      else if (off == 1)               m_data = 8'(int'(pend[c]) + 2 * int'(aen[c]) + 4 * int'(tflag[c]));
      else if (off <= 16)              m_data = 8'(sh[c][off]);
    end
    snap = sh;
    for (int i = 0; i < NUM_CH; i++) was_pend[i] = pend[i];
    if (w && hit) begin
      if (off == 0) begin
        sh[c][0] = int'(d[0]);
        if (d[2]) tflag[c] = 0;
        if (d[1] && !was_pend[c]) begin pend[c] = 1; age[c] = 0; end
      end else if (off >= 2 && off <= 16) begin
        sh[c][off] = int'(d);
      end
    end
    for (int i = 0; i < NUM_CH; i++) begin
      m_done[i] = 1'b0;
      if (was_pend[i]) begin
        forced = 0;
`ifdef PGREG_SYNC_TIMEOUT_EN
        forced = (age[i] == TO - 1);
`endif
        if (s[i] || !aen[i] || forced) begin
          aen[i]  = (snap[i][0] != 0);
          ay[i]   = snap[i][2] * 256 + snap[i][3];
          am[i]   = snap[i][4]; ad[i] = snap[i][5]; ah[i] = snap[i][6];
          ami[i]  = snap[i][7]; asec[i] = snap[i][8];
          awh[i]  = (snap[i][9] << 24) + (snap[i][10] << 16) + (snap[i][11] << 8) + snap[i][12];
          awp[i]  = (snap[i][13] << 24) + (snap[i][14] << 16) + (snap[i][15] << 8) + snap[i][16];
          pend[i] = 0;
          m_done[i] = 1'b1;
          if (forced && !s[i]) tflag[i] = 1;
        end else begin
          age[i]++;
        end
      end
    end
  endtask

  task automatic compare_all();
    logic [NUM_CH-1:0]    e_en;
    logic [NUM_CH*16-1:0] e_y;
    logic [NUM_CH*8-1:0]  e_mo, e_d, e_h, e_mi, e_s;
    logic [NUM_CH*32-1:0] e_wh, e_wp;
    for (int i = 0; i < NUM_CH; i++) begin
      e_en[i]         = aen[i];
      e_y[i*16 +: 16] = 16'(ay[i]);
      e_mo[i*8 +: 8]  = 8'(am[i]);
      e_d[i*8 +: 8]   = 8'(ad[i]);
      e_h[i*8 +: 8]   = 8'(ah[i]);
      e_mi[i*8 +: 8]  = 8'(ami[i]);
      e_s[i*8 +: 8]   = 8'(asec[i]);
      e_wh[i*32 +: 32] = awh[i];
      e_wp[i*32 +: 32] = awp[i];
    end
    check("o_data", rdata, m_data);
    check("commit_done", done, m_done);
    check("pulse_enable", pen, e_en);
    check("year", year, e_y);
    check("date_time", {month, day, hour, minutes, seconds}, {e_mo, e_d, e_h, e_mi, e_s});
    check("width_high", wh, e_wh);
    check("width_period", wp, e_wp);
  endtask

  // Called just after an active edge: drive, take one edge, update model, compare
  task automatic apply(input bit w, input logic [7:0] a, input logic [7:0] d, input logic [NUM_CH-1:0] s);
    wr = w; addr = a; wdata = d; sync = s;
    @(posedge clk);
    #1;
    model_edge(w, a, d, s);
    compare_all();
  endtask

  task automatic check_all_zero(input string name);
    check(name, {rdata, done, pen, year, month, day, hour, minutes, seconds, wh, wp}, '0);
  endtask

  typedef struct {
    bit               w;
    logic [7:0]       a;
    logic [7:0]       d;
    logic [NUM_CH-1:0] s;
    logic [7:0]       exp_data;
    logic [NUM_CH-1:0] exp_done;
    logic [NUM_CH-1:0] exp_en;
    logic [31:0]      exp_wh1;
    logic [31:0]      exp_wp1;
  } vec_t;

  vec_t tbl [$];
  int   k;
  logic [7:0] ra;

  initial begin
    // ch1 WIDTH_HIGH=1000, WIDTH_PERIOD=10000, enable+commit, then WIDTH_HIGH=2000 via i_sync
    tbl.push_back(vec_t'{1'b1, 8'h49, 8'h00, 4'h0, 8'h00, 4'h0, 4'h0, 32'd0, 32'd0});
    tbl.push_back(vec_t'{1'b1, 8'h4A, 8'h00, 4'h0, 8'h00, 4'h0, 4'h0, 32'd0, 32'd0});
    tbl.push_back(vec_t'{1'b1, 8'h4B, 8'h03, 4'h0, 8'h00, 4'h0, 4'h0, 32'd0, 32'd0});
    tbl.push_back(vec_t'{1'b1, 8'h4C, 8'hE8, 4'h0, 8'h00, 4'h0, 4'h0, 32'd0, 32'd0});
    tbl.push_back(vec_t'{1'b1, 8'h4D, 8'h00, 4'h0, 8'h00, 4'h0, 4'h0, 32'd0, 32'd0});
    tbl.push_back(vec_t'{1'b1, 8'h4E, 8'h00, 4'h0, 8'h00, 4'h0, 4'h0, 32'd0, 32'd0});
    tbl.push_back(vec_t'{1'b1, 8'h4F, 8'h27, 4'h0, 8'h00, 4'h0, 4'h0, 32'd0, 32'd0});
    tbl.push_back(vec_t'{1'b1, 8'h50, 8'h10, 4'h0, 8'h00, 4'h0, 4'h0, 32'd0, 32'd0});
    tbl.push_back(vec_t'{1'b1, 8'h40, 8'h03, 4'h0, 8'h00, 4'h0, 4'h0, 32'd0, 32'd0});
    tbl.push_back(vec_t'{1'b0, 8'h41, 8'h00, 4'h0, 8'h01, 4'h2, 4'h2, 32'd1000, 32'd10000});
    tbl.push_back(vec_t'{1'b0, 8'h41, 8'h00, 4'h0, 8'h02, 4'h0, 4'h2, 32'd1000, 32'd10000});
    tbl.push_back(vec_t'{1'b0, 8'h4C, 8'h00, 4'h0, 8'hE8, 4'h0, 4'h2, 32'd1000, 32'd10000});
    tbl.push_back(vec_t'{1'b1, 8'h49, 8'h00, 4'h0, 8'h00, 4'h0, 4'h2, 32'd1000, 32'd10000});
    tbl.push_back(vec_t'{1'b1, 8'h4A, 8'h00, 4'h0, 8'h00, 4'h0, 4'h2, 32'd1000, 32'd10000});
    tbl.push_back(vec_t'{1'b1, 8'h4B, 8'h07, 4'h0, 8'h00, 4'h0, 4'h2, 32'd1000, 32'd10000});
    tbl.push_back(vec_t'{1'b1, 8'h4C, 8'hD0, 4'h0, 8'h00, 4'h0, 4'h2, 32'd1000, 32'd10000});
    tbl.push_back(vec_t'{1'b1, 8'h40, 8'h03, 4'h0, 8'h00, 4'h0, 4'h2, 32'd1000, 32'd10000});
    tbl.push_back(vec_t'{1'b0, 8'h41, 8'h00, 4'h0, 8'h03, 4'h0, 4'h2, 32'd1000, 32'd10000});
    tbl.push_back(vec_t'{1'b0, 8'h41, 8'h00, 4'h0, 8'h03, 4'h0, 4'h2, 32'd1000, 32'd10000});
    tbl.push_back(vec_t'{1'b0, 8'h41, 8'h00, 4'h2, 8'h03, 4'h2, 4'h2, 32'd2000, 32'd10000});
    tbl.push_back(vec_t'{1'b0, 8'h41, 8'h00, 4'h0, 8'h02, 4'h0, 4'h2, 32'd2000, 32'd10000});

    rst_n = 1'b0; wr = 1'b0; addr = '0; wdata = '0; sync = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset_outputs");
    rst_n = 1'b1;

    // Every offset of every channel reads 0 after reset
    for (int c = 0; c < NUM_CH; c++)
      for (int o = 0; o < 32; o++) begin
        ra = 8'(32 + c * 32 + o);
        apply(1'b0, ra, 8'h00, '0);
        check("reset_read", rdata, 8'h00);
      end

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].s);
      check("tbl_o_data", rdata, tbl[i].exp_data);
      check("tbl_commit_done", done, tbl[i].exp_done);
      check("tbl_enable", pen, tbl[i].exp_en);
      check("tbl_ch1_width_high", wh[63:32], tbl[i].exp_wh1);
      check("tbl_ch1_width_period", wp[63:32], tbl[i].exp_wp1);
    end

    // ch0: shadow write coinciding with the transfer
    apply(1'b1, 8'h20, 8'h03, '0);
    apply(1'b0, 8'h00, 8'h00, '0);
    apply(1'b1, 8'h23, 8'h11, '0);
    apply(1'b1, 8'h20, 8'h03, '0);
    apply(1'b1, 8'h23, 8'h55, 4'b0001);
    check("same_cycle_year_low", year[7:0], 8'h11);
    check("same_cycle_done", done[0], 1'b1);
    apply(1'b0, 8'h23, 8'h00, '0);
    check("same_cycle_shadow", rdata, 8'h55);
    apply(1'b0, 8'h21, 8'h00, '0);
    check("same_cycle_idle", rdata, 8'h02);

    // ch2: reset while pending
    apply(1'b1, 8'h60, 8'h03, '0);
    apply(1'b0, 8'h00, 8'h00, '0);
    apply(1'b1, 8'h6C, 8'h5A, '0);
    apply(1'b1, 8'h60, 8'h03, '0);
    apply(1'b0, 8'h61, 8'h00, '0);
    check("pending_before_reset", rdata, 8'h03);
    check("enables_before_reset", pen, 4'b0111);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    apply(1'b0, 8'h61, 8'h00, '0);
    check("status_after_reset", rdata, 8'h00);
    repeat (3) apply(1'b0, 8'h00, 8'h00, 4'b0100);
    check("no_commit_after_reset", {done, pen}, '0);

    // ch3: pending with no i_sync
    apply(1'b1, 8'h80, 8'h03, '0);
    apply(1'b0, 8'h00, 8'h00, '0);
    apply(1'b1, 8'h80, 8'h03, '0);
    k = 0;
    for (int n = 1; n <= 40 && k == 0; n++) begin
      apply(1'b0, 8'h81, 8'h00, '0);
      if (done[3]) k = n;
    end
`ifdef PGREG_SYNC_TIMEOUT_EN
    check("timeout_latency", k, TO);
    apply(1'b0, 8'h81, 8'h00, '0);
    check("timeout_flag", rdata, 8'h06);
    apply(1'b1, 8'h80, 8'h04, '0);
    apply(1'b0, 8'h81, 8'h00, '0);
    check("timeout_flag_clear", rdata, 8'h02);
`else
    check("no_forced_commit", k, 0);
    apply(1'b0, 8'h81, 8'h00, '0);
    check("still_pending", rdata, 8'h03);
    apply(1'b0, 8'h00, 8'h00, 4'b1000);
    check("sync_releases", done[3], 1'b1);
`endif

    // Random traffic against the model
    for (int n = 0; n < 800; n++) begin
      logic [7:0] a, d;
      logic [NUM_CH-1:0] s;
      bit w;
      w = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 3) != 0) a = 8'($urandom_range(32, 32 + NUM_CH * 32 - 1));
      else                           a = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 2) == 0) a = 8'(32 + $urandom_range(0, NUM_CH - 1) * 32);
      d = 8'($urandom);
      s = '0;
      for (int i = 0; i < NUM_CH; i++) s[i] = ($urandom_range(0, 9) == 0);
      apply(w, a, d, s);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
